// File: rtl/comp_pipe_pkg.sv
// Shared compare-code, signedness and decision-state encodings for the pipelined comparator.
package comp_pipe_pkg;

  localparam logic [1:0] COMP_EQ = 2'b00;
  localparam logic [1:0] COMP_LE = 2'b01;
  localparam logic [1:0] COMP_GE = 2'b10;

  localparam logic UNSIGNED = 1'b1;
  localparam logic SIGNED   = 1'b0;

  typedef enum logic [1:0] {
    UNDECIDED = 2'b00,
    LESS      = 2'b01,
    GREATER   = 2'b10
  } dec_t;

endpackage

// File: rtl/comp_slice.sv
// One slice of the MSB-first compare: resolves an undecided state from a SLICE-bit pair.
module comp_slice
  import comp_pipe_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  dec_t             dec_in,
  output dec_t             dec_out
);

  always_comb begin
    dec_out = dec_in;
    if (dec_in == UNDECIDED) begin
      if (a < b)      dec_out = LESS;
      else if (a > b) dec_out = GREATER;
    end
  end

endmodule

// File: rtl/comp_pipe.sv
// Pipelined signed/unsigned magnitude comparator, one SLICE per stage, whole-pipe stall.
// Optional min/max select output enabled by defining COMP_MINMAX_EN.
module comp_pipe
  import comp_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  input  logic [TAG_W-1:0] in_tag,
`ifdef COMP_MINMAX_EN
  input  logic             min_sel,
  output logic [WIDTH-1:0] sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       cmp,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;
  localparam logic [SLICE-1:0] SIGN_BIT = SLICE'(1) << (SLICE - 1);

  function automatic logic [1:0] dec_to_cmp(input dec_t d);
    case (d)
      LESS:    return COMP_LE;
      GREATER: return COMP_GE;
      default: return COMP_EQ;
    endcase
  endfunction

  logic             advance;
  logic [SLICE-1:0] top_a, top_b;
  logic             vld_p [STAGES];
  dec_t             dec_p [STAGES];
  logic [TAG_W-1:0] tag_p [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Only the top slice carries the sign bit; flipping it maps two's-complement onto unsigned order.
  assign top_a = a[WIDTH-1 -: SLICE] ^ ((is_unsigned == SIGNED) ? SIGN_BIT : '0);
  assign top_b = b[WIDTH-1 -: SLICE] ^ ((is_unsigned == SIGNED) ? SIGN_BIT : '0);

  for (genvar k = 0; k < STAGES; k++) begin : st
`ifndef COMP_MINMAX_EN
    localparam int REM = WIDTH - (k + 1) * SLICE;
`endif
    logic [SLICE-1:0] sa, sb;
    dec_t             dec_in, dec_out;
    logic             vld_in;
    logic [TAG_W-1:0] tag_in;
`ifdef COMP_MINMAX_EN
    logic [WIDTH-1:0] a_in, b_in, a_r, b_r;
    logic             msel_in, msel_r;
`endif

    if (k == 0) begin : src
      assign sa     = top_a;
      assign sb     = top_b;
      assign dec_in = UNDECIDED;
      assign vld_in = in_valid;
      assign tag_in = in_tag;
`ifdef COMP_MINMAX_EN
      assign a_in    = a;
      assign b_in    = b;
      assign msel_in = min_sel;
`endif
    end else begin : src
`ifdef COMP_MINMAX_EN
      assign sa      = st[k-1].a_r[WIDTH-1-k*SLICE -: SLICE];
      assign sb      = st[k-1].b_r[WIDTH-1-k*SLICE -: SLICE];
      assign a_in    = st[k-1].a_r;
      assign b_in    = st[k-1].b_r;
      assign msel_in = st[k-1].msel_r;
`else
      assign sa = st[k-1].hold.a_r[REM+SLICE-1 -: SLICE];
      assign sb = st[k-1].hold.b_r[REM+SLICE-1 -: SLICE];
`endif
      assign dec_in = dec_p[k-1];
      assign vld_in = vld_p[k-1];
      assign tag_in = tag_p[k-1];
    end

    comp_slice #(.SLICE(SLICE)) u_slice (
      .a      (sa),
      .b      (sb),
      .dec_in (dec_in),
      .dec_out(dec_out)
    );

    // Stage k boundary: control, decision and tag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p[k] <= 1'b0;
        dec_p[k] <= UNDECIDED;
        tag_p[k] <= '0;
      end else if (advance) begin
        vld_p[k] <= vld_in;
        dec_p[k] <= dec_out;
        tag_p[k] <= tag_in;
      end
    end

`ifdef COMP_MINMAX_EN
    // Raw operands ride the whole pipe so sel can return them; cleared so sel reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_r    <= '0;
        b_r    <= '0;
        msel_r <= 1'b0;
      end else if (advance) begin
        a_r    <= a_in;
        b_r    <= b_in;
        msel_r <= msel_in;
      end
    end
`else
    // Only slices still to be compared are carried forward.
    if (REM > 0) begin : hold
      logic [REM-1:0] a_r, b_r;
      if (k == 0) begin : ld
        always_ff @(posedge clk) begin
          if (advance) begin
            a_r <= a[REM-1:0];
            b_r <= b[REM-1:0];
          end
        end
      end else begin : ld
        always_ff @(posedge clk) begin
          if (advance) begin
            a_r <= st[k-1].hold.a_r[REM-1:0];
            b_r <= st[k-1].hold.b_r[REM-1:0];
          end
        end
      end
    end
`endif
  end

  assign out_valid = vld_p[LAST];
  assign out_tag   = tag_p[LAST];
  assign cmp       = dec_to_cmp(dec_p[LAST]);

`ifdef COMP_MINMAX_EN
  always_comb begin
    sel = st[LAST].a_r;
    if (st[LAST].msel_r) begin
      if (dec_p[LAST] == GREATER) sel = st[LAST].b_r;
    end else begin
      if (dec_p[LAST] == LESS) sel = st[LAST].b_r;
    end
  end
`endif

endmodule

// File: tb/tb_comp_pipe.sv
// Scoreboard bench for comp_pipe: directed vectors, latency, streaming, backpressure, reset flush.
// Exercises the min/max select when COMP_MINMAX_EN is defined.
module tb_comp_pipe;
  import comp_pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             is_unsigned = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [1:0]       cmp;
  logic [TAG_W-1:0] out_tag;
`ifdef COMP_MINMAX_EN
  logic             min_sel = 1'b0;
  logic [WIDTH-1:0] sel;
`endif

  typedef struct {
    logic [1:0]       cmp;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] sel;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [1:0]  ec;
  } vec_t;

  exp_t sb_q[$];
  int   pop_cyc[$];
  exp_t mon_e;
  vec_t tbl[16];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  comp_pipe #(.WIDTH(WIDTH), .SLICE(SLICE), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .is_unsigned(is_unsigned),
    .in_tag     (in_tag),
`ifdef COMP_MINMAX_EN
    .min_sel    (min_sel),
    .sel        (sel),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cmp        (cmp),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_sel(input logic [31:0] va, input logic [31:0] vb,
                                          input logic [1:0] ec, input logic ms);
    if (ms) return (ec == COMP_GE) ? vb : va;
    return (ec == COMP_LE) ? vb : va;
  endfunction

  // Monitor: every consumed result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      check("result_expected", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("cmp", cmp, mon_e.cmp);
        check("tag", out_tag, mon_e.tag);
`ifdef COMP_MINMAX_EN
        check("sel", sel, mon_e.sel);
`endif
      end
    end
  end

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic uns,
                      input logic [3:0] tag, input logic [1:0] ec, input logic ms,
                      output int stalls);
    bit ok;
    exp_t e;
    stalls = 0;
    a = va;
    b = vb;
    is_unsigned = uns;
    in_tag = tag;
    in_valid = 1'b1;
`ifdef COMP_MINMAX_EN
    min_sel = ms;
`endif
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
      if (!ok) stalls++;
    end while (!ok && stalls < 50);
    if (ok) begin
      e.cmp = ec;
      e.tag = tag;
      e.sel = exp_sel(va, vb, ec, ms);
      sb_q.push_back(e);
    end else begin
      check("accept_timeout", ok, 1);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    int st, tot, lat, ovc;
    logic [1:0] sv_cmp;
    logic [TAG_W-1:0] sv_tag;

    tbl = '{
      '{32'h00000001, 32'h00000002, UNSIGNED, COMP_LE},
      '{32'h00000002, 32'h00000001, UNSIGNED, COMP_GE},
      '{32'hDEADBEEF, 32'hDEADBEEF, UNSIGNED, COMP_EQ},
      '{32'hDEADBEEF, 32'hDEADBEEF, SIGNED,   COMP_EQ},
      '{32'h80000000, 32'h7FFFFFFF, SIGNED,   COMP_LE},
      '{32'h80000000, 32'h7FFFFFFF, UNSIGNED, COMP_GE},
      '{32'hFFFFFFFE, 32'hFFFFFFFF, SIGNED,   COMP_LE},
      '{32'h00010000, 32'h0000FFFF, UNSIGNED, COMP_GE},
      '{32'h00FF0000, 32'h00FF0001, SIGNED,   COMP_LE},
      '{32'h12340000, 32'h12350000, UNSIGNED, COMP_LE},
      '{32'hA5A5A5A5, 32'h5A5A5A5A, UNSIGNED, COMP_GE},
      '{32'hA5A5A5A5, 32'h5A5A5A5A, SIGNED,   COMP_LE},
      '{32'h00000000, 32'h00000000, SIGNED,   COMP_EQ},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, UNSIGNED, COMP_EQ},
      '{32'h01000000, 32'h00FFFFFF, UNSIGNED, COMP_GE},
      '{32'h7FFFFFFF, 32'hFFFFFFFF, SIGNED,   COMP_GE}
    };

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_cmp", cmp, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("idle_in_ready", in_ready, 1);

    // Same data, signed then unsigned, with latency measured in edges
    send(32'hFFFFFFFF, 32'h00000000, SIGNED, 4'h1, COMP_LE, 1'b0, st);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check("latency_signed", lat, 4);
    @(posedge clk);
    #2;
    send(32'hFFFFFFFF, 32'h00000000, UNSIGNED, 4'h2, COMP_GE, 1'b0, st);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check("latency_unsigned", lat, 4);
    drain("drain_latency");

    // Decision in the LSB slice, and signed equality on the sign bit
    send(32'h12345678, 32'h12345679, UNSIGNED, 4'h3, COMP_LE, 1'b0, st);
    send(32'h80000000, 32'h80000000, SIGNED,   4'h4, COMP_EQ, 1'b0, st);
    send(32'h00000005, 32'hFFFFFFFD, SIGNED,   4'h5, COMP_GE, 1'b0, st);
    in_valid = 1'b0;
    drain("drain_directed");

    // Back-to-back stream, tags 0..15
    pop_cyc.delete();
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].uns, 4'(i), tbl[i].ec, 1'b0, st);
      tot += st;
    end
    in_valid = 1'b0;
    check("stream_stalls", tot, 0);
    drain("drain_stream");
    check("stream_count", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) check("stream_rate", pop_cyc[15] - pop_cyc[0], 15);

    // Backpressure: out_ready low for 5 cycles mid-stream
    pop_cyc.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(tbl[i].a, tbl[i].b, tbl[i].uns, 4'(i), tbl[i].ec, 1'b0, st);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        out_ready = 1'b0;
        @(negedge clk);
        sv_cmp = cmp;
        sv_tag = out_tag;
        check("bp_out_valid", out_valid, 1);
        for (int j = 0; j < 5; j++) begin
          check("bp_in_ready", in_ready, 0);
          if (j > 0) begin
            check("bp_cmp_hold", cmp, sv_cmp);
            check("bp_tag_hold", out_tag, sv_tag);
          end
          if (j < 4) @(negedge clk);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_count", pop_cyc.size(), 10);

    // Reset with three operations in flight
    send(tbl[4].a, tbl[4].b, tbl[4].uns, 4'hA, tbl[4].ec, 1'b0, st);
    send(tbl[6].a, tbl[6].b, tbl[6].uns, 4'hB, tbl[6].ec, 1'b0, st);
    send(tbl[1].a, tbl[1].b, tbl[1].uns, 4'hC, tbl[1].ec, 1'b0, st);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_cmp", cmp, 0);
    check("mid_rst_out_tag", out_tag, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ovc = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    check("post_rst_no_result", ovc, 0);

`ifdef COMP_MINMAX_EN
    // Min/max select on -5 vs 3, signed, plus equal operands
    @(posedge clk);
    #2;
    send(32'hFFFFFFFB, 32'h00000003, SIGNED, 4'h6, COMP_LE, 1'b1, st);
    send(32'hFFFFFFFB, 32'h00000003, SIGNED, 4'h7, COMP_LE, 1'b0, st);
    send(32'h00000009, 32'h00000009, UNSIGNED, 4'h8, COMP_EQ, 1'b1, st);
    in_valid = 1'b0;
    drain("drain_minmax");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
